// File: rtl/flappy_if.sv
// Engine-side bundle between the stdin io block, the game engine and the ANSI view.
interface flappy_if #(
    parameter int COORD_W = 8,
    parameter int N_PIPE  = 3,
    parameter int SCORE_W = 16
);
    logic                          key;
    logic [COORD_W-1:0]            n_row;
    logic [COORD_W-1:0]            n_col;
    logic [1:0]                    scene;
    logic [COORD_W-1:0]            altitude;
    logic                          is_flapping;
    logic [3*COORD_W*N_PIPE-1:0]   pipes;
    logic [SCORE_W-1:0]            score;

    modport master (
        output key, n_row, n_col,
        input  scene, altitude, is_flapping, pipes, score
    );

    modport slave (
        input  key, n_row, n_col,
        output scene, altitude, is_flapping, pipes, score
    );
endinterface

// File: rtl/flappy_engine.sv
// Frame-rate game-state engine for terminal Flappy Bird: fixed-point bird physics,
// a ring of N_PIPE scrolling pipes with LFSR gaps, scoring and auto-restart.
module flappy_engine #(
    parameter int           N_PIPE       = 3,
    parameter int           COORD_W      = 8,
    parameter int           FRAC_W       = 8,
    parameter int           GAP_LEN      = 8,
    parameter int           PIPE_SPACING = 50,
    parameter int           SCROLL_DIV   = 3,
    parameter int           BIRD_COL     = 10,
    parameter int           KP_BUFLEN    = 5,
    parameter int           ACC1         = -4,
    parameter int           ACC2         = -6,
    parameter int           VEL_BND      = 26,
    parameter int           VEL0         = 70,
    parameter int           GO_HOLD      = 90,
    parameter int           SCORE_W      = 16,
    parameter logic [15:0]  LFSR_SEED    = 16'hACE1
) (
    input  logic     clk,
    input  logic     rst_n,
    flappy_if.slave  bus
);
    localparam int Y_W   = COORD_W + FRAC_W + 2;
    localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int GO_W  = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;

    localparam logic [1:0] SPLASH   = 2'd0;
    localparam logic [1:0] PLAYING  = 2'd1;
    localparam logic [1:0] GAMEOVER = 2'd2;

    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SCROLL_DIV - 1);
    localparam logic [GO_W-1:0]        GO_LAST   = GO_W'(GO_HOLD - 1);
    localparam logic signed [Y_W-1:0]  ACC1_S    = Y_W'(ACC1);
    localparam logic signed [Y_W-1:0]  ACC2_S    = Y_W'(ACC2);
    localparam logic signed [Y_W-1:0]  VEL0_S    = Y_W'(VEL0);
    localparam logic signed [Y_W-1:0]  VEL_BND_S = Y_W'(VEL_BND);
    localparam logic signed [Y_W-1:0]  Y_MAX     = {1'b0, {(Y_W-1){1'b1}}};
    localparam logic signed [Y_W-1:0]  Y_MIN     = {1'b1, {(Y_W-1){1'b0}}};
    localparam logic [COORD_W-1:0]     HIT_LO    = COORD_W'(BIRD_COL - 6);
    localparam logic [COORD_W-1:0]     HIT_HI    = COORD_W'(BIRD_COL + 2);

    function automatic logic signed [Y_W-1:0] sat_add(input logic signed [Y_W-1:0] p,
                                                      input logic signed [Y_W-1:0] q);
        logic signed [Y_W:0] s;
        s = {p[Y_W-1], p} + {q[Y_W-1], q};
        if (s[Y_W] != s[Y_W-1])
            return s[Y_W] ? Y_MIN : Y_MAX;
        return s[Y_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (&s) ? s : s + SCORE_W'(1);
    endfunction

    logic [1:0]               scene;
    logic signed [Y_W-1:0]    y, v, a;
    logic [KP_BUFLEN-1:0]     kpbuf;
    logic                     is_flapping;
    logic [COORD_W-1:0]       pos  [N_PIPE];
    logic [COORD_W-1:0]       pmin [N_PIPE];
    logic [COORD_W-1:0]       pmax [N_PIPE];
    logic [CNT_W-1:0]         cnt;
    logic [GO_W-1:0]          go_cnt;
    logic [SCORE_W-1:0]       score;
    logic [15:0]              lfsr;

    logic                     flap, hit, dead, step, recycle, world_init;
    logic [COORD_W-1:0]       altitude, min_init, new_min;
    logic [15:0]              gap_rng;
    logic signed [Y_W-1:0]    top_y, y_init, y_sum, v_sum;
    logic                     unused_n_col;

    assign unused_n_col = ^bus.n_col;

    assign flap     = |kpbuf;
    assign top_y    = {2'b00, bus.n_row - COORD_W'(1), {FRAC_W{1'b0}}};
    assign y_init   = {3'b000, bus.n_row[COORD_W-1:1], {FRAC_W{1'b0}}};
    assign min_init = (bus.n_row - COORD_W'(GAP_LEN)) >> 1;
    assign gap_rng  = 16'(bus.n_row - COORD_W'(GAP_LEN));
    assign new_min  = COORD_W'(lfsr % gap_rng);
    assign y_sum    = sat_add(y, v);
    assign v_sum    = sat_add(v, a);
    assign altitude = y[Y_W-1] ? '0 : y[FRAC_W +: COORD_W];

    assign hit        = (pos[0] >= HIT_LO) && (pos[0] <= HIT_HI) &&
                        ((altitude <= pmin[0]) || (altitude >= pmax[0]));
    assign dead       = (scene == PLAYING) && (y[Y_W-1] || hit);
    assign step       = (scene == PLAYING) && (cnt == CNT_LAST);
    assign recycle    = step && (pos[0] == '0);
    assign world_init = !rst_n || ((scene == GAMEOVER) && (go_cnt == GO_LAST));

    // The LFSR free-runs through every scene so each game sees fresh gaps.
    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Score survives the auto-restart; only a new start or reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            score <= '0;
        else if ((scene == SPLASH) && bus.key)
            score <= '0;
        else if (step && (pos[0] == HIT_LO) && !dead)
            score <= sat_inc(score);
    end

    always_ff @(posedge clk) begin
        if (world_init) begin
            scene       <= SPLASH;
            y           <= y_init;
            v           <= VEL0_S;
            a           <= ACC1_S;
            is_flapping <= 1'b0;
            kpbuf       <= '0;
            cnt         <= '0;
            go_cnt      <= '0;
            for (int i = 0; i < N_PIPE; i++) begin
                pos[i]  <= COORD_W'(PIPE_SPACING * (i + 1));
                pmin[i] <= min_init;
                pmax[i] <= min_init + COORD_W'(GAP_LEN);
            end
        end else begin
            kpbuf <= {bus.key, kpbuf[KP_BUFLEN-1:1]};
            case (scene)
                SPLASH: begin
                    if (bus.key)
                        scene <= PLAYING;
                end
                PLAYING: begin
                    a           <= (v > VEL_BND_S) ? ACC1_S : ACC2_S;
                    is_flapping <= flap;
                    // Ceiling clamp takes priority over a flap.
                    if (y_sum > top_y) begin
                        y <= top_y;
                        v <= '0;
                    end else begin
                        y <= y_sum;
                        v <= flap ? VEL0_S : v_sum;
                    end
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                    if (recycle) begin
                        for (int i = 0; i < N_PIPE - 1; i++) begin
                            pos[i]  <= pos[i+1];
                            pmin[i] <= pmin[i+1];
                            pmax[i] <= pmax[i+1];
                        end
                        pos[N_PIPE-1]  <= pos[N_PIPE-1] + COORD_W'(PIPE_SPACING);
                        pmin[N_PIPE-1] <= new_min;
                        pmax[N_PIPE-1] <= new_min + COORD_W'(GAP_LEN);
                    end else if (step) begin
                        for (int i = 0; i < N_PIPE; i++)
                            pos[i] <= pos[i] - COORD_W'(1);
                    end
                    if (dead)
                        scene <= GAMEOVER;
                end
                GAMEOVER: begin
                    go_cnt <= go_cnt + GO_W'(1);
                end
                default: begin
                    scene <= SPLASH;
                end
            endcase
        end
    end

    assign bus.scene       = scene;
    assign bus.altitude    = altitude;
    assign bus.is_flapping = is_flapping;
    assign bus.score       = score;

    for (genvar g = 0; g < N_PIPE; g++) begin : g_pipes
        assign bus.pipes[3*COORD_W*g +: 3*COORD_W] = {pos[g], pmax[g], pmin[g]};
    end
endmodule

// File: tb/tb_flappy_engine.sv
// Directed bench for flappy_engine: a default-physics instance and a zero-physics
// instance share clock and reset; expectations are hand-derived frame counts.
module tb_flappy_engine;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    flappy_if #(.COORD_W(8), .N_PIPE(3), .SCORE_W(16)) ifc ();
    flappy_if #(.COORD_W(8), .N_PIPE(3), .SCORE_W(16)) zifc ();

    flappy_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    flappy_engine #(.ACC1(0), .ACC2(0), .VEL0(0)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (zifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11; lfsr_prev is the value
    // the DUT held just before the most recent edge.
    logic [15:0] lfsr_m, lfsr_prev;
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (!rst_n)
            lfsr_m <= 16'hACE1;
        else
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_pos(input logic [71:0] p, input int i);
        return {24'd0, p[24*i+16 +: 8]};
    endfunction

    function automatic logic [31:0] f_max(input logic [71:0] p, input int i);
        return {24'd0, p[24*i+8 +: 8]};
    endfunction

    function automatic logic [31:0] f_min(input logic [71:0] p, input int i);
        return {24'd0, p[24*i +: 8]};
    endfunction

    initial begin
        logic [31:0] alt_max;
        logic [31:0] last_pos;
        logic [15:0] exp_min;

        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        ifc.key   = 1'b0;
        ifc.n_row = 8'd40;
        ifc.n_col = 8'd80;
        zifc.key   = 1'b0;
        zifc.n_row = 8'd40;
        zifc.n_col = 8'd80;

        // Reset state
        tick(2);
        chk("rst_scene",    32'(ifc.scene), 0);
        chk("rst_altitude", 32'(ifc.altitude), 20);
        chk("rst_pos0",     f_pos(ifc.pipes, 0), 50);
        chk("rst_max0",     f_max(ifc.pipes, 0), 24);
        chk("rst_min0",     f_min(ifc.pipes, 0), 16);
        chk("rst_pos2",     f_pos(ifc.pipes, 2), 150);
        chk("rst_score",    32'(ifc.score), 0);
        chk("rst_flap",     32'(ifc.is_flapping), 0);

        // Splash is frozen until a key arrives
        rst_n = 1'b1;
        tick(4);
        chk("splash_scene", 32'(ifc.scene), 0);
        chk("splash_pos0",  f_pos(ifc.pipes, 0), 50);
        ifc.key = 1'b1;
        tick(1);
        ifc.key = 1'b0;
        chk("start_scene",  32'(ifc.scene), 1);
        chk("start_flap",   32'(ifc.is_flapping), 0);
        chk("start_alt",    32'(ifc.altitude), 20);
        tick(3);
        chk("scroll_pos0",  f_pos(ifc.pipes, 0), 49);
        chk("scroll_alt",   32'(ifc.altitude), 20);
        tick(2);
        chk("flap5_on",     32'(ifc.is_flapping), 1);
        chk("flap5_alt",    32'(ifc.altitude), 21);
        tick(1);
        chk("flap5_off",    32'(ifc.is_flapping), 0);

        // No more keys: the bird falls below the floor
        for (int i = 0; i < 300; i++) begin
            if (ifc.scene == 2'd2) break;
            tick(1);
        end
        chk("fall_scene",  32'(ifc.scene), 2);
        chk("fall_alt",    32'(ifc.altitude), 0);
        chk("fall_score",  32'(ifc.score), 0);
        tick(10);
        ifc.key = 1'b1;
        tick(1);
        ifc.key = 1'b0;
        chk("go_key_ignored", 32'(ifc.scene), 2);
        tick(78);
        chk("go_hold_last",   32'(ifc.scene), 2);
        tick(1);
        chk("restart_scene",  32'(ifc.scene), 0);
        chk("restart_alt",    32'(ifc.altitude), 20);
        chk("restart_pos0",   f_pos(ifc.pipes, 0), 50);
        chk("restart_score",  32'(ifc.score), 0);
        chk("restart_flap",   32'(ifc.is_flapping), 0);

        // Key held every frame: ceiling clamp, then a hit at the upper pipe
        ifc.key = 1'b1;
        tick(1);
        chk("ceil_start", 32'(ifc.scene), 1);
        alt_max  = 0;
        last_pos = 0;
        for (int i = 0; i < 400; i++) begin
            if (ifc.scene != 2'd1) break;
            if (32'(ifc.altitude) > alt_max) alt_max = 32'(ifc.altitude);
            last_pos = f_pos(ifc.pipes, 0);
            tick(1);
        end
        ifc.key = 1'b0;
        chk("ceil_max_alt",  alt_max, 39);
        chk("hit_scene",     32'(ifc.scene), 2);
        chk("hit_last_pos",  last_pos, 12);
        chk("hit_pos0",      f_pos(ifc.pipes, 0), 12);
        chk("hit_alt",       32'(ifc.altitude), 39);
        chk("hit_score",     32'(ifc.score), 0);

        // Synchronous reset in the middle of a game
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        ifc.key = 1'b1;
        tick(1);
        ifc.key = 1'b0;
        tick(10);
        chk("mid_scene", 32'(ifc.scene), 1);
        chk("mid_pos0",  f_pos(ifc.pipes, 0), 47);
        rst_n = 1'b0;
        #1;
        chk("sync_rst_wait", 32'(ifc.scene), 1);
        tick(1);
        chk("midrst_scene", 32'(ifc.scene), 0);
        chk("midrst_alt",   32'(ifc.altitude), 20);
        chk("midrst_pos0",  f_pos(ifc.pipes, 0), 50);
        chk("midrst_pos2",  f_pos(ifc.pipes, 2), 150);
        chk("midrst_min0",  f_min(ifc.pipes, 0), 16);
        chk("midrst_max0",  f_max(ifc.pipes, 0), 24);

        // Zero-physics instance: scoring and ring recycle
        tick(1);
        rst_n = 1'b1;
        tick(1);
        zifc.key = 1'b1;
        tick(1);
        zifc.key = 1'b0;
        chk("z_start",      32'(zifc.scene), 1);
        tick(140);
        chk("z_pre_score",  32'(zifc.score), 0);
        chk("z_pre_pos0",   f_pos(zifc.pipes, 0), 4);
        tick(1);
        chk("z_score",      32'(zifc.score), 1);
        chk("z_score_pos0", f_pos(zifc.pipes, 0), 3);
        chk("z_alt",        32'(zifc.altitude), 20);
        chk("z_scene",      32'(zifc.scene), 1);
        tick(11);
        chk("z_at_zero",    f_pos(zifc.pipes, 0), 0);
        chk("z_last_before", f_pos(zifc.pipes, 2), 100);
        tick(1);
        exp_min = lfsr_prev % 16'd32;
        chk("z_rec_pos0",   f_pos(zifc.pipes, 0), 50);
        chk("z_rec_min0",   f_min(zifc.pipes, 0), 16);
        chk("z_rec_pos1",   f_pos(zifc.pipes, 1), 100);
        chk("z_rec_pos2",   f_pos(zifc.pipes, 2), 150);
        chk("z_rec_min2",   f_min(zifc.pipes, 2), 32'(exp_min));
        chk("z_rec_max2",   f_max(zifc.pipes, 2), 32'(exp_min) + 8);
        chk("z_rec_score",  32'(zifc.score), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
